// File: rtl/serial_flow_acc.sv
// Bit-serial multi-channel adder / comparator: one result bit per consumed input bit,
// with a full scan chain over all state flops.
module serial_flow_acc #(
  parameter int WORD_W = 8,
  parameter int NCH    = 2
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [NCH-1:0] line,
  input  logic           in_valid,
  input  logic           mode,
  input  logic           test_si,
  input  logic           test_se,
  output logic           outp,
  output logic           out_valid,
  output logic           word_done,
  output logic           overflw,
  output logic           test_so
);

  localparam int CW    = $clog2(NCH);
  localparam int BW    = $clog2(WORD_W);
  localparam int SW    = CW + 1;
  localparam int CHAIN = 6 + CW + BW;

  logic [BW-1:0]    bit_cnt;
  logic [CW-1:0]    carry;
  logic             mode_q;
  logic             mism;
  logic [SW-1:0]    pop;
  logic [SW-1:0]    sum;
  logic             mode_eff;
  logic             last;
  logic             neq;
  logic [CHAIN-1:0] chain;

  // popcount + carry peaks at 2*NCH-1, which always fits in CW+1 bits
  always_comb begin
    pop = '0;
    for (int i = 0; i < NCH; i++) begin
      pop = pop + SW'(line[i]);
    end
  end

  assign sum      = pop + SW'(carry);
  assign mode_eff = (bit_cnt == '0) ? mode : mode_q;
  assign last     = (bit_cnt == BW'(WORD_W - 1));
  assign neq      = !((&line) || !(|line));

  // LSB of the chain is the flop nearest test_si
  assign chain   = {bit_cnt, carry, mism, mode_q, word_done, out_valid, overflw, outp};
  assign test_so = bit_cnt[BW-1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bit_cnt   <= '0;
      carry     <= '0;
      mode_q    <= 1'b0;
      mism      <= 1'b0;
      outp      <= 1'b0;
      out_valid <= 1'b0;
      word_done <= 1'b0;
      overflw   <= 1'b0;
    end else if (test_se) begin
      {bit_cnt, carry, mism, mode_q, word_done, out_valid, overflw, outp}
        <= {chain[CHAIN-2:0], test_si};
    end else if (in_valid) begin
      out_valid <= 1'b1;
      word_done <= last;
      if (bit_cnt == '0) begin
        mode_q <= mode;
      end
      if (mode_eff) begin
        outp <= ^line;
      end else begin
        outp <= sum[0];
      end
      if (last) begin
        bit_cnt <= '0;
        carry   <= '0;
        mism    <= 1'b0;
        overflw <= mode_eff ? (mism | neq) : (sum[SW-1:1] != '0);
      end else begin
        bit_cnt <= bit_cnt + BW'(1);
        overflw <= 1'b0;
        if (mode_eff) begin
          mism <= mism | neq;
        end else begin
          carry <= sum[SW-1:1];
        end
      end
    end else begin
      out_valid <= 1'b0;
      word_done <= 1'b0;
      overflw   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_flow_acc.sv
// Directed bench for serial_flow_acc: table of per-bit vectors plus reset and scan sequences.
module tb_serial_flow_acc;

  localparam int WORD_W = 8;
  localparam int NCH    = 2;
  localparam int CH     = 6 + $clog2(NCH) + $clog2(WORD_W);

  logic           clock;
  logic           reset;
  logic [NCH-1:0] line;
  logic           in_valid;
  logic           mode;
  logic           test_si;
  logic           test_se;
  logic           outp;
  logic           out_valid;
  logic           word_done;
  logic           overflw;
  logic           test_so;

  typedef struct {
    logic [NCH-1:0] line;
    logic           vld;
    logic           md;
    logic           e_outp;
    logic           e_valid;
    logic           e_done;
    logic           e_ovf;
    string          tag;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  serial_flow_acc #(.WORD_W(WORD_W), .NCH(NCH)) dut (
    .clock     (clock),
    .reset     (reset),
    .line      (line),
    .in_valid  (in_valid),
    .mode      (mode),
    .test_si   (test_si),
    .test_se   (test_se),
    .outp      (outp),
    .out_valid (out_valid),
    .word_done (word_done),
    .overflw   (overflw),
    .test_so   (test_so)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    line     = v.line;
    in_valid = v.vld;
    mode     = v.md;
    @(posedge clock);
    #1;
    checkOutput($sformatf("%s[%0d].outp", v.tag, idx), outp, v.e_outp);
    checkOutput($sformatf("%s[%0d].out_valid", v.tag, idx), out_valid, v.e_valid);
    checkOutput($sformatf("%s[%0d].word_done", v.tag, idx), word_done, v.e_done);
    checkOutput($sformatf("%s[%0d].overflw", v.tag, idx), overflw, v.e_ovf);
  endtask

  // One record per consumed bit, plus three idle records after each bit flagged in gap
  task automatic push_word(input logic [7:0] a, input logic [7:0] b, input logic md,
                           input logic flip, input logic [7:0] exp_word, input logic exp_ovf,
                           input logic [7:0] gap, input int nbits, input string tag);
    vec_t v;
    for (int i = 0; i < nbits; i++) begin
      v.line    = {b[i], a[i]};
      v.vld     = 1'b1;
      v.md      = (i != 0 && flip) ? ~md : md;
      v.e_outp  = exp_word[i];
      v.e_valid = 1'b1;
      v.e_done  = (i == WORD_W - 1);
      v.e_ovf   = (i == WORD_W - 1) ? exp_ovf : 1'b0;
      v.tag     = tag;
      vecs.push_back(v);
      if (gap[i]) begin
        for (int g = 0; g < 3; g++) begin
          v.line    = 2'b11;
          v.vld     = 1'b0;
          v.md      = ~md;
          v.e_valid = 1'b0;
          v.e_done  = 1'b0;
          v.e_ovf   = 1'b0;
          v.tag     = {tag, "_idle"};
          vecs.push_back(v);
        end
      end
    end
  endtask

  task automatic run_vectors();
    foreach (vecs[k]) applyStimulus(vecs[k], k);
    vecs.delete();
  endtask

  logic pat [CH] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    clock    = 1'b0;
    reset    = 1'b0;
    line     = '0;
    in_valid = 1'b0;
    mode     = 1'b0;
    test_si  = 1'b0;
    test_se  = 1'b0;

    #2;
    checkOutput("reset.outp", outp, 1'b0);
    checkOutput("reset.out_valid", out_valid, 1'b0);
    checkOutput("reset.word_done", word_done, 1'b0);
    checkOutput("reset.overflw", overflw, 1'b0);
    checkOutput("reset.test_so", test_so, 1'b0);
    #5 reset = 1'b1;

    push_word(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 8'h00, 8, "add");
    push_word(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 8, "ovf");
    push_word(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 8'h00, 8, "after_ovf");
    push_word(8'hA5, 8'hA4, 1'b1, 1'b1, 8'h01, 1'b1, 8'h00, 8, "cmp_ne");
    push_word(8'hA5, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 8, "cmp_eq");
    push_word(8'hA5, 8'h25, 1'b1, 1'b0, 8'h80, 1'b1, 8'h00, 8, "cmp_last");
    push_word(8'h5A, 8'h3C, 1'b0, 1'b1, 8'h96, 1'b0, 8'h00, 8, "add_flip");
    push_word(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 8'h44, 8, "gap");
    run_vectors();

    // Abandon a word after four bits while the carry is 1
    push_word(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 8'h00, 4, "pre_rst");
    run_vectors();
    #2 reset = 1'b0;
    #1;
    checkOutput("midrst.outp", outp, 1'b0);
    checkOutput("midrst.out_valid", out_valid, 1'b0);
    checkOutput("midrst.word_done", word_done, 1'b0);
    checkOutput("midrst.overflw", overflw, 1'b0);
    checkOutput("midrst.test_so", test_so, 1'b0);
    @(posedge clock);
    #1;
    checkOutput("midrst_hold.out_valid", out_valid, 1'b0);
    #2 reset = 1'b1;
    push_word(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 8'h00, 8, "post_rst");
    run_vectors();

    // Scan: chain starts cleared, functional inputs kept active to expose leaks
    #2 reset = 1'b0;
    #1 reset = 1'b1;
    test_se  = 1'b1;
    in_valid = 1'b1;
    line     = 2'b11;
    mode     = 1'b1;
    for (int j = 0; j < 2 * CH - 1; j++) begin
      test_si = (j < CH) ? pat[j] : 1'b0;
      @(posedge clock);
      #1;
      checkOutput($sformatf("scan[%0d].test_so", j), test_so,
                  (j >= CH - 1) ? pat[j - CH + 1] : 1'b0);
    end
    test_se  = 1'b0;
    in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
